// File: rtl/io_uart_peripheral_pkg.sv
// rtl/io_uart_peripheral_pkg.sv - shared io-space decode constants for the UART/LED/tick peripheral
package io_uart_peripheral_pkg;

    localparam int CPU_WIDTH = 16;

    localparam logic [1:0] IO_TXDATA = 2'd0;
    localparam logic [1:0] IO_STATUS = 2'd1;
    localparam logic [1:0] IO_LEDS   = 2'd2;
    localparam logic [1:0] IO_TICKS  = 2'd3;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVERFLOW = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // io space is anything outside the bottom quarter of the address map
    function automatic logic io_sel(input logic [CPU_WIDTH-1:0] addr);
        return addr[CPU_WIDTH-1 -: 2] != 2'b00;
    endfunction

endpackage

// File: rtl/io_uart_peripheral_if.sv
// rtl/io_uart_peripheral_if.sv - CPU io bus between the stack CPU and its io responders
interface io_uart_peripheral_if
    import io_uart_peripheral_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_WIDTH
);
    logic [DATA_WIDTH-1:0] io_addr;
    logic                  io_write;
    logic [DATA_WIDTH-1:0] io_wr_data;
    logic [DATA_WIDTH-1:0] io_rd_data;

    modport master (output io_addr, output io_write, output io_wr_data, input  io_rd_data);
    modport slave  (input  io_addr, input  io_write, input  io_wr_data, output io_rd_data);
endinterface

// File: rtl/io_uart_peripheral_serializer.sv
// rtl/io_uart_peripheral_serializer.sv - 8N1 UART transmit state machine with registered line output
module uart_tx_serializer
    import io_uart_peripheral_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       pop_o,
    output logic       tx_o,
    output logic       busy_o
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_last;

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line register follows the state one clock later, giving the
    // two-clock write-to-start-bit latency while staying glitch-free.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_o   = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (valid_i) begin
                    pop_o   = 1'b1;
                    shift_d = data_i;
                    baud_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    // chain straight into the next frame so queued bytes leave no idle gap
                    if (valid_i) begin
                        pop_o   = 1'b1;
                        shift_d = data_i;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != TX_IDLE);

endmodule

// File: rtl/io_uart_peripheral.sv
// rtl/io_uart_peripheral.sv - io-bus responder: UART TX FIFO, LED register and millisecond tick counter
module io_uart_peripheral
    import io_uart_peripheral_pkg::*;
#(
    parameter int DATA_WIDTH   = CPU_WIDTH,
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 2,
    parameter int TICK_DIV     = 25000
) (
    input  logic                  clock,
    input  logic                  reset,
    io_uart_peripheral_if.slave   bus,
    output logic                  uart_tx,
    output logic [3:0]            leds
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [7:0]         fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         leds_q, leds_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [15:0]        ticks_q, ticks_d;

    logic sel, wr_en, wr_txdata, wr_status, wr_leds, wr_ticks;
    logic fifo_empty, fifo_full, push, pop, ser_busy, presc_wrap;
    logic [1:0] offset;
    logic [3:0] status;
    logic unused_bits;

    assign sel       = io_sel(CPU_WIDTH'(bus.io_addr));
    assign offset    = bus.io_addr[1:0];
    assign wr_en     = sel && bus.io_write;
    assign wr_txdata = wr_en && (offset == IO_TXDATA);
    assign wr_status = wr_en && (offset == IO_STATUS);
    assign wr_leds   = wr_en && (offset == IO_LEDS);
    assign wr_ticks  = wr_en && (offset == IO_TICKS);
    assign unused_bits = ^{bus.io_addr[DATA_WIDTH-3:2], bus.io_wr_data[DATA_WIDTH-1:8]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
    // a full FIFO still accepts a byte when the serializer drains one in the same cycle
    assign push       = wr_txdata && (!fifo_full || pop);
    assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock  (clock),
        .reset  (reset),
        .valid_i(!fifo_empty),
        .data_i (fifo_mem_q[rd_ptr_q]),
        .pop_o  (pop),
        .tx_o   (uart_tx),
        .busy_o (ser_busy)
    );

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        overflow_d = overflow_q;
        if (wr_status && bus.io_wr_data[ST_OVERFLOW]) overflow_d = 1'b0;
        if (wr_txdata && !push) overflow_d = 1'b1;
        leds_d     = wr_leds ? bus.io_wr_data[3:0] : leds_q;
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        ticks_d    = presc_wrap ? ticks_q + 1'b1 : ticks_q;
        if (wr_ticks) begin
            presc_d = '0;
            ticks_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            leds_q     <= '0;
            presc_q    <= '0;
            ticks_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            leds_q     <= leds_d;
            presc_q    <= presc_d;
            ticks_q    <= ticks_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.io_wr_data[7:0];
    end

    always_comb begin
        status              = '0;
        status[ST_FULL]     = fifo_full;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_BUSY]     = ser_busy;
        status[ST_OVERFLOW] = overflow_q;
        bus.io_rd_data      = '0;
        if (sel) begin
            case (offset)
                IO_STATUS: bus.io_rd_data = DATA_WIDTH'(status);
                IO_LEDS:   bus.io_rd_data = DATA_WIDTH'(leds_q);
                IO_TICKS:  bus.io_rd_data = DATA_WIDTH'(ticks_q);
                default:   bus.io_rd_data = '0;
            endcase
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_io_uart_peripheral.sv
// tb/tb_io_uart_peripheral.sv - scoreboard bench for the io UART/LED/tick peripheral
module tb_io_uart_peripheral;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_tx;
    logic [3:0] leds;

    io_uart_peripheral_if #(.DATA_WIDTH(16)) bus ();

    io_uart_peripheral #(
        .DATA_WIDTH  (16),
        .CLKS_PER_BIT(4),
        .FIFO_AW     (2),
        .TICK_DIV    (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .uart_tx(uart_tx),
        .leds   (leds)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rst_count = 0;
    logic [7:0] exp_q [$];

    always @(posedge reset) rst_count++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_addr    = a;
        bus.io_wr_data = d;
        bus.io_write   = 1'b1;
        @(negedge clock);
        bus.io_write   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        bus.io_addr = a;
        #1;
        check(nm, 32'(bus.io_rd_data), 32'(e));
    endtask

    task automatic drain(input int max_clks);
        for (int i = 0; i < max_clks && exp_q.size() != 0; i++) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
        end
    endtask

    // UART receiver: samples mid-bit on falling clock edges, drops frames cut by reset
    initial begin : monitor
        logic [7:0] b;
        int         rc;
        forever begin
            @(negedge clock);
            if (!reset && uart_tx === 1'b0) begin
                rc = rst_count;
                repeat (5) @(negedge clock);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clock);
                if (rst_count == rc) begin
                    check("stop_bit", 32'(uart_tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got 0x%0h expected no frame", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] byte0;
        logic       eb;
        bus.io_addr    = '0;
        bus.io_write   = 1'b0;
        bus.io_wr_data = '0;
        repeat (3) @(negedge clock);

        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_leds", 32'(leds), 32'd0);
        rd(16'h4001, 16'h0002, "rst_status");
        rd(16'h4003, 16'h0000, "rst_ticks");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        byte0 = 8'h41;
        exp_q.push_back(byte0);
        wr(16'h4000, 16'h0041);
        for (int k = 0; k < 42; k++) begin
            if (k < 2)       eb = 1'b1;
            else if (k < 6)  eb = 1'b0;
            else if (k < 38) eb = byte0[(k - 6) / 4];
            else             eb = 1'b1;
            check($sformatf("tx_wave[%0d]", k), 32'(uart_tx), 32'(eb));
            @(negedge clock);
        end
        rd(16'h4001, 16'h0002, "status_after_frame");

        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(8'h30 + i));
        for (int i = 1; i <= 6; i++) wr(16'h4000, 16'(8'h30 + i));
        rd(16'h4001, 16'h000D, "status_overflow_full");
        wr(16'h4001, 16'h0008);
        rd(16'h4001, 16'h0005, "status_overflow_cleared");
        drain(400);
        repeat (10) @(negedge clock);
        rd(16'h4001, 16'h0002, "status_after_burst");

        wr(16'h4002, 16'h0005);
        check("leds_written", 32'(leds), 32'h5);
        rd(16'h4002, 16'h0005, "leds_read");
        wr(16'h0002, 16'h000A);
        check("leds_unselected", 32'(leds), 32'h5);
        rd(16'h0002, 16'h0000, "read_unselected");
        rd(16'h4002, 16'h0005, "leds_read_again");

        wr(16'h4003, 16'h0000);
        rd(16'h4003, 16'h0000, "ticks_cleared");
        repeat (80) @(posedge clock);
        @(negedge clock);
        rd(16'h4003, 16'h000A, "ticks_80_clocks");
        wr(16'h4003, 16'h0000);
        force dut.ticks_q = 16'hFFFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        release dut.ticks_q;
        rd(16'h4003, 16'hFFFF, "ticks_preload");
        repeat (4) @(posedge clock);
        @(negedge clock);
        rd(16'h4003, 16'hFFFF, "ticks_before_wrap");
        @(posedge clock);
        @(negedge clock);
        rd(16'h4003, 16'h0000, "ticks_wrapped");

        wr(16'h4000, 16'h00A5);
        wr(16'h4000, 16'h0011);
        wr(16'h4000, 16'h0022);
        repeat (8) @(negedge clock);
        check("tx_mid_data", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        #1;
        check("tx_async_reset", 32'(uart_tx), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        rd(16'h4001, 16'h0002, "status_after_reset");
        check("leds_after_reset", 32'(leds), 32'd0);
        repeat (60) @(negedge clock);
        check("tx_idle_after_reset", 32'(uart_tx), 32'd1);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
